// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the pixel-clock PLL lock sequencer.
package pll_seq_pkg;

  localparam logic [2:0] ST_HOLD_RST  = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  localparam int LOST_CNT_W = 8;

  typedef enum logic [2:0] {
    HOLD_RST  = ST_HOLD_RST,
    WAIT_LOCK = ST_WAIT_LOCK,
    STABLE    = ST_STABLE,
    RUN       = ST_RUN,
    FAULT     = ST_FAULT
  } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser, clears to 0 on asynchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock qualification sequencer with timeout, bounded retries and fault.
// Optional lock-loss counter enabled by defining PLL_SEQ_LOST_CNT_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  ready,
  output logic                  fault,
  output logic                  lock_lost,
  output logic [1:0]            retry_cnt,
  output logic [LOST_CNT_W-1:0] lost_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  logic             lk_s;
  pll_state_e       state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       retry_nxt;
  logic             lost_ev;

  sync_2ff u_lk_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  always_comb begin
    nxt       = state;
    cnt_nxt   = cnt + CNT_W'(1);
    retry_nxt = retry_cnt;
    lost_ev   = 1'b0;
    if (relock_req) begin
      nxt       = HOLD_RST;
      retry_nxt = '0;
    end else begin
      case (state)
        HOLD_RST:  if (cnt == HOLD_LAST) nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lk_s) nxt = STABLE;
          else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_nxt = retry_cnt + 2'd1;
              nxt       = HOLD_RST;
            end else begin
              nxt = FAULT;
            end
          end
        end
        STABLE: begin
          if (!lk_s) nxt = WAIT_LOCK;
          else if (cnt == STABLE_LAST) begin
            nxt       = RUN;
            retry_nxt = '0;
          end
        end
        RUN: begin
          if (!lk_s) begin
            nxt     = HOLD_RST;
            lost_ev = 1'b1;
          end
        end
        FAULT:   nxt = FAULT;
        default: nxt = HOLD_RST;
      endcase
    end
    // RUN and FAULT have no timed exit, so their counter idles at zero
    if (relock_req || nxt != state || state == RUN || state == FAULT)
      cnt_nxt = '0;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_rst   <= (nxt == HOLD_RST) || (nxt == FAULT);
      sys_rst_n <= (nxt == RUN);
      ready     <= (nxt == RUN);
      fault     <= (nxt == FAULT);
      lock_lost <= lost_ev;
    end
  end

`ifdef PLL_SEQ_LOST_CNT_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      lost_cnt <= '0;
    else if (lost_ev && lost_cnt != '1)
      lost_cnt <= lost_cnt + LOST_CNT_W'(1);
  end
`else
  assign lost_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomised bench for pll_lock_sequencer against a dwell-time reference model.
module tb_pll_lock_sequencer;

  localparam int RH = 4, LS = 8, TO = 32, MR = 2;
  localparam logic [14:0] RST_VEC = 15'h4000;

  logic       refclk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, relock_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault, lock_lost;
  logic [1:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic [14:0] outs;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES(RH), .LOCK_STABLE_CYCLES(LS), .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MR), .CNT_W(16)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
    .lock_lost(lock_lost), .retry_cnt(retry_cnt), .lost_cnt(lost_cnt)
  );

  always #5 refclk = ~refclk;

  assign outs = {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt, lost_cnt};

  int n_chk = 0, n_err = 0;
  int k, first_rise, n_fall, n_lost, hi, base;
  bit rdy_prev, prst_prev;

  // reference model: phase plus the edge it was entered, lock seen two edges late
  typedef enum {P_RST, P_WAIT, P_QUAL, P_RUN, P_FAULT} ph_t;
  ph_t ph;
  int  t0, tries, lost;
  bit  m_s1, m_s2, e_lost;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, k);
    end
  endtask

  function automatic logic [14:0] exp_outs();
    logic [7:0] l;
`ifdef PLL_SEQ_LOST_CNT_EN
    l = 8'(lost);
`else
    l = 8'd0;
`endif
    return {(ph == P_RST) || (ph == P_FAULT), ph == P_RUN, ph == P_RUN, ph == P_FAULT,
            e_lost, 2'(tries), l};
  endfunction

  task automatic model_edge(input bit pl, input bit rq);
    bit  lk = m_s2;
    int  dt = k - t0;
    ph_t nx = ph;
    m_s2 = m_s1; m_s1 = pl; e_lost = 0;
    if (rq) begin
      nx = P_RST; tries = 0;
    end else begin
      case (ph)
        P_RST:  if (dt == RH) nx = P_WAIT;
        P_WAIT: if (lk) nx = P_QUAL;
                else if (dt == TO) begin
                  if (tries < MR) begin tries++; nx = P_RST; end
                  else nx = P_FAULT;
                end
        P_QUAL: if (!lk) nx = P_WAIT;
                else if (dt == LS) begin nx = P_RUN; tries = 0; end
        P_RUN:  if (!lk) begin nx = P_RST; e_lost = 1; if (lost < 255) lost++; end
        default: ;
      endcase
    end
    if (rq || nx != ph) t0 = k;
    ph = nx;
  endtask

  task automatic step(input bit pl, input bit rq);
    pll_locked = pl; relock_req = rq;
    @(posedge refclk);
    k++;
    model_edge(pl, rq);
    @(negedge refclk);
    relock_req = 1'b0;
    chk("outs", outs, exp_outs());
    if (ready && !rdy_prev && first_rise < 0) first_rise = k;
    if (prst_prev && !pll_rst) n_fall++;
    rdy_prev = ready; prst_prev = pll_rst;
    n_lost += int'(lock_lost);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
    repeat (3) @(negedge refclk);
    chk("rst_vals", outs, RST_VEC);
    ph = P_RST; t0 = 0; k = 0; tries = 0; lost = 0; m_s1 = 0; m_s2 = 0; e_lost = 0;
    first_rise = -1; n_fall = 0; rdy_prev = 0; prst_prev = 1;
    rst_n = 1'b1;
    #1 chk("post_rel", outs, exp_outs());
  endtask

  initial begin
    // nominal lock
    do_reset();
    hi = int'(pll_rst);
    for (int c = 0; c < 30; c++) begin
      step(c >= 10, 0);
      if (c < 10) hi += int'(pll_rst);
    end
    chk("rst_hold", hi, RH);
    chk("rdy_edge", first_rise, 21);
    chk("retry0", retry_cnt, 0);

    // one-cycle glitch while qualifying
    do_reset();
    for (int c = 0; c < 40; c++) step(c >= 10 && c != 14, 0);
    chk("glitch_rdy", first_rise, 26);
    chk("glitch_retry", retry_cnt, 0);

    // timeout into fault
    do_reset();
    for (int c = 0; c < 120; c++) step(0, 0);
    chk("rst_pulses", n_fall, 3);
    chk("fault", fault, 1);
    chk("fault_prst", pll_rst, 1);
    for (int c = 0; c < 10; c++) step(0, 0);
    chk("fault_hold", {fault, pll_rst}, 2'b11);

    // recovery from fault
    step(1, 1);
    base = k; first_rise = -1;
    chk("rec_fault", fault, 0);
    chk("rec_retry", retry_cnt, 0);
    for (int c = 0; c < 20; c++) step(1, 0);
    chk("rec_rdy", first_rise - base, RH + LS + 1);

    // loss in RUN, then saturation of the loss counter
    n_lost = 0;
    for (int c = 0; c < 6; c++) step(0, 0);
    chk("lost_pulse", n_lost, 1);
`ifdef PLL_SEQ_LOST_CNT_EN
    chk("lost_cnt1", lost_cnt, 1);
`else
    chk("lost_cnt1", lost_cnt, 0);
`endif
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 20; c++) step(1, 0);
      for (int c = 0; c < 4; c++) step(0, 0);
    end
    chk("lost_pulses", n_lost, 301);
`ifdef PLL_SEQ_LOST_CNT_EN
    chk("lost_sat", lost_cnt, 255);
`else
    chk("lost_sat", lost_cnt, 0);
`endif

    // relock_req coinciding with lock loss in RUN
    for (int c = 0; c < 20; c++) step(1, 0);
    chk("run_rdy", ready, 1);
    step(0, 0); step(0, 0); step(0, 1);
    chk("sim_lost", lock_lost, 0);
    chk("sim_state", {pll_rst, ready}, 2'b10);

    // asynchronous reset while qualifying lock
    for (int c = 0; c < 9; c++) step(1, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", outs, RST_VEC);
    do_reset();

    // random lock activity with occasional relock requests
    for (int s = 0; s < 300; s++) begin
      int len = $urandom_range(1, 150);
      bit pl  = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) step(pl, $urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset and lock sequencer for the 25.175 MHz pixel-clock PLL. Runs on the 50 MHz reference clock, drives the PLL reset and qualifies its `locked` output with a synchroniser, a stability filter and a timeout with bounded retries. Produces a clean `sys_rst_n` and `ready` for the VGA and game logic, and reports persistent lock failure as a fault.

## Interface
- `RST_HOLD_CYCLES`, default 16: number of refclk cycles that PLL reset is held per attempt.
- `LOCK_STABLE_CYCLES`, default 1024: number of consecutive synchronised-lock cycles required before `ready`.
- `LOCK_TIMEOUT_CYCLES`, default 50000: maximum wait for lock per attempt (1 ms).
- `MAX_RETRIES`, default 3: number of extra attempts allowed before fault.
- `CNT_W`, default 16: width of the shared cycle counter. It must hold the largest of the three cycle parameters.
- `refclk` in, 1 bit: 50 MHz reference clock.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `pll_locked` in, 1 bit: PLL lock. Asynchronous to `refclk`.
- `relock_req` in, 1 bit: single-cycle request to restart the sequence.
- `pll_rst` out, 1 bit: reset to the PLL, active-high.
- `sys_rst_n` out, 1 bit: downstream reset, active-low.
- `ready` out, 1 bit: PLL locked and qualified.
- `fault` out, 1 bit: retries exhausted.
- `lock_lost` out, 1 bit: one-cycle pulse when lock drops in RUN.
- `retry_cnt` out, 2 bits: number of failed attempts in the current sequence.
- `lost_cnt` out, 8 bits: count of lock losses. See Configuration.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `lk_s`. All decisions use `lk_s`.
- States:
  - **HOLD_RST**: `pll_rst`=1. Count up to `RST_HOLD_CYCLES`-1, then go to WAIT_LOCK and clear the counter.
  - **WAIT_LOCK**: `pll_rst`=0.
    - `lk_s`=1: go to STABLE and clear the counter.
    - Counter reaches `LOCK_TIMEOUT_CYCLES`-1 and `retry_cnt`<`MAX_RETRIES`: increment `retry_cnt`, go to HOLD_RST.
    - Counter reaches `LOCK_TIMEOUT_CYCLES`-1 and `retry_cnt`=`MAX_RETRIES`: go to FAULT.
  - **STABLE**: `pll_rst`=0.
    - `lk_s`=0: go to WAIT_LOCK with the counter cleared and no retry increment.
    - Counter reaches `LOCK_STABLE_CYCLES`-1: go to RUN and clear `retry_cnt`.
  - **RUN**: `ready`=1, `sys_rst_n`=1. `lk_s`=0 pulses `lock_lost` and goes to HOLD_RST.
  - **FAULT**: `pll_rst`=1, `fault`=1. Leaves only on `relock_req`.
- `relock_req` in any state goes to HOLD_RST and clears the counter and `retry_cnt`. It has priority over every other transition.
  - `relock_req` together with lock loss in RUN: no `lock_lost` pulse, and `lost_cnt` is not incremented.
- `retry_cnt` saturates at `MAX_RETRIES`. It never wraps.
- The counter is cleared on every state change.

## Timing
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Values during reset and on the first cycle after release:
  - State HOLD_RST with the counter at 0.
  - `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fault`=0, `lock_lost`=0.
  - `retry_cnt`=0, `lost_cnt`=0.
- `pll_rst` stays high for exactly `RST_HOLD_CYCLES` cycles after `rst_n` deasserts.
- With `pll_locked` held high, `ready` and `sys_rst_n` rise exactly `LOCK_STABLE_CYCLES`+3 edges after `pll_locked` rises: 2 synchroniser edges, 1 transition edge, then the stable count.
- Lock drop in RUN:
  - `ready`=0 and `sys_rst_n`=0 three edges after `pll_locked` falls.
  - `lock_lost` is high for exactly that one cycle.
- `relock_req` takes effect on the next edge.
- Asserting `rst_n` mid-sequence forces the reset values immediately (asynchronously).

## Configuration
- `PLL_SEQ_LOST_CNT_EN` defined: `lost_cnt` is an 8-bit counter that increments on each `lock_lost` pulse and saturates at 255. It is cleared only by `rst_n`.
- `PLL_SEQ_LOST_CNT_EN` undefined: `lost_cnt` is tied to 0 and no counter logic is generated.

## Structure
- Package `pll_seq_pkg` holds:
  - the state enum: HOLD_RST, WAIT_LOCK, STABLE, RUN, FAULT;
  - the 3-bit state encoding constants;
  - the `lost_cnt` width constant.
- Sub-module `sync_2ff`: a single-bit 2-flop synchroniser with asynchronous active-low reset to 0, instantiated for `pll_locked`.

## Test plan
All scenarios use `RST_HOLD_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `MAX_RETRIES`=2.
- Nominal lock: release reset, raise `pll_locked` at cycle 10 and hold it high.
  - `pll_rst` is high for cycles 0-3.
  - `ready` and `sys_rst_n` rise at edge 21.
  - `retry_cnt` stays 0.
- Glitch in STABLE: raise `pll_locked` at cycle 10 and drop it for 1 cycle at cycle 14.
  - Returns to WAIT_LOCK and `ready` stays 0.
  - After relock, `ready` rises 11 edges after the final rise.
  - `retry_cnt` stays 0.
- Timeout and fault: hold `pll_locked` low.
  - `retry_cnt` steps 1, then 2.
  - 3 HOLD_RST pulses of 4 cycles are seen.
  - `fault`=1 with `pll_rst`=1 after the third timeout, and both hold.
- Recovery from FAULT: pulse `relock_req` with `pll_locked` high.
  - `fault`=0 and `retry_cnt`=0 on the next edge.
  - `pll_rst` is high for 4 cycles, then `ready` is reached.
- Loss in RUN: drop `pll_locked` while in RUN.
  - `lock_lost` is one cycle high.
  - `ready`=0 3 edges after the drop.
  - With the macro defined, `lost_cnt`=1.
  - Repeating 300 times gives `lost_cnt`=255.
- Simultaneous events and mid-sequence reset:
  - `relock_req` in the same cycle that `lk_s` falls in RUN: `lock_lost`=0 and state is HOLD_RST.
  - Asserting `rst_n` during STABLE: all outputs return to their reset values with no clock edge.
